fb_pair_loader: RTL
===================

# fb_pair_loader

Upstream feeder for the foo/bar assertion-check stage. Accepts a stream of 32-bit write words over a valid/ready handshake, buffers them in a small FIFO, and loads them alternately into the `foo` and `bar` operand registers. When a `foo`/`bar` pair is loaded it presents the pair with `pair_valid` and holds it until the downstream stage acknowledges with `rd`. It also precomputes the low-bit check the downstream stage asserts on, and keeps a sticky error flag.

## Interface
- `DEPTH`, 4, FIFO depth in words; power of two, ≥2
- `W`, 32, word width
- `CHECK_BITS`, 10, number of low bits that must be set in both `foo` and `bar`
- `clk`  in  1  sole clock; all state updates on posedge
- `rst`  in  1  reset; synchronous, active-high
- `wr_valid`  in  1  `wdata` valid
- `wdata`  in  W  write word
- `wr_ready`  out  1  FIFO can accept a word
- `rd`  in  1  downstream acknowledge of the current pair
- `pair_valid`  out  1  `foo`/`bar` hold a complete, unacknowledged pair
- `foo`  out  W  first operand register
- `bar`  out  W  second operand register
- `pair_ok`  out  1  `&(foo[CHECK_BITS-1:0] & bar[CHECK_BITS-1:0])`
- `err_seen`  out  1  sticky: a pair with `pair_ok=0` was acknowledged
- `fifo_count`  out  $clog2(DEPTH+1)  current FIFO occupancy

## Operation
- **Reset values**
  - FIFO is empty: `fifo_count=0`, `wr_ready=1`.
  - State is `LOAD_FOO` and `pair_valid=0`.
  - `foo=32'hFFFF_FFFA`, `bar=32'hFFFF_FFFB`, so `pair_ok=0`.
  - `err_seen=0`.
- **Push**
  - Occurs on `wr_valid && wr_ready`.
  - `wr_ready = (fifo_count < DEPTH)`. It depends only on the count, never on `rd` or on a same-cycle pop.
  - While `wr_ready=0`, `wr_valid` is ignored, and the word is not captured.
- **Pop**
  - Occurs in `LOAD_FOO` or `LOAD_BAR` when `fifo_count>0`.
  - A push and a pop in the same cycle leave `fifo_count` unchanged.
  - Pointers wrap modulo `DEPTH`.
- **FSM states**
  - `LOAD_FOO`: on pop, `foo<=head` and go to `LOAD_BAR`. If the FIFO is empty, stay.
  - `LOAD_BAR`: on pop, `bar<=head` and go to `HOLD`. If the FIFO is empty, stay with `foo` already updated.
  - `HOLD`: `pair_valid=1`. On `rd`, go to `LOAD_FOO`. No pop occurs in `HOLD`.
- **`rd` outside `HOLD`** is ignored.
- **Operand registers** `foo` and `bar` change only on their own pop. After an acknowledge they keep their old values until overwritten.
- **`pair_ok`** is combinational from the `foo`/`bar` registers.
- **`err_seen`** sets on `pair_valid && rd && !pair_ok`. Only `rst` clears it.
- **Reset mid-operation** applies the reset values regardless of state. Buffered words are discarded.

## Timing
- **Single-word latency:** a word pushed at the edge ending cycle t appears on `foo` in cycle t+2.
- **Back-to-back pair:** with words pushed in cycles t and t+1, `bar` updates and `pair_valid=1` in cycle t+3.
- **Acknowledge:** `rd` in cycle h drops `pair_valid` in h+1. The earliest next `foo` load is visible in h+2.
- **Throughput:** maximum is one pair per 3 cycles (`LOAD_FOO`, `LOAD_BAR`, `HOLD` with immediate `rd`).
- **Registered outputs:** all outputs except `wr_ready` and `pair_ok` come directly from flops. `wr_ready` and `pair_ok` are single-level decodes of flops.

## Structure
- **Package `fb_pkg`:**
  - state enum `fb_state_e {LOAD_FOO, LOAD_BAR, HOLD}`
  - `FOO_RST=32'hFFFF_FFFA`
  - `BAR_RST=32'hFFFF_FFFB`
  - `CHECK_BITS_DEF=10`
- **Sub-module `fb_fifo`:** parameterised DEPTH×W synchronous FIFO with push/pop, count, full/empty, and synchronous active-high `rst`.
- **Top level:** FSM, operand registers, check logic and sticky flag.

## Test plan
- **Reset and idle:** reset, then idle 5 cycles → `foo=FFFFFFFA`, `bar=FFFFFFFB`, `pair_valid=0`, `pair_ok=0`, `fifo_count=0`, `wr_ready=1`.
- **Good pair:** push `0x3FF` then `0xFFFF_FFFF` in consecutive cycles → `pair_valid` rises exactly 3 cycles after the first push, `pair_ok=1`. `rd` → `pair_valid` low next cycle, `err_seen=0`.
- **Bad pair:** push `0x1FF`, `0x3FF`, then `rd` in `HOLD` → `pair_ok=0`, and `err_seen=1` from the next cycle, persisting through further good pairs.
- **Backpressure:** hold `rd=0` and push 7 words with `wr_valid` constantly high → after 2 pops, `fifo_count` saturates at 4 and `wr_ready=0`. The 7th word is not accepted until `rd` frees a slot. No word is lost or duplicated, checked by order in `foo`/`bar`.
- **Simultaneous push and pop:** push and pop in the same cycle at count 2 → count stays 2. Pointer wrap is checked over 10 consecutive words, with pair order preserved.
- **Reset mid-operation:** `rst` asserted in `LOAD_BAR` with 3 words buffered → reset values next cycle. Words pushed afterward start at `foo`.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and constants for the foo/bar pair loader.
package fb_pkg;

    typedef enum logic [1:0] {
        LOAD_FOO,
        LOAD_BAR,
        HOLD
    } fb_state_e;

    localparam logic [31:0] FOO_RST        = 32'hFFFF_FFFA;
    localparam logic [31:0] BAR_RST        = 32'hFFFF_FFFB;
    localparam int unsigned CHECK_BITS_DEF = 10;

endpackage

// File: rtl/fb_fifo.sv
// DEPTH x W synchronous FIFO; DEPTH must be a power of two so pointers wrap naturally.
module fb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               dout_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rptr_q];
    assign count_o = count_q;

    always_comb begin
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: stale words are unreachable once pointers are cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fb_pair_loader.sv
// Buffers write words and loads them alternately into foo/bar, presenting each pair until acknowledged.
module fb_pair_loader
    import fb_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned W          = 32,
    parameter int unsigned CHECK_BITS = CHECK_BITS_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    input  logic [W-1:0]               wdata,
    output logic                       wr_ready,
    input  logic                       rd,
    output logic                       pair_valid,
    output logic [W-1:0]               foo,
    output logic [W-1:0]               bar,
    output logic                       pair_ok,
    output logic                       err_seen,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam logic [W-1:0] FOO_INIT = W'(FOO_RST);
    localparam logic [W-1:0] BAR_INIT = W'(BAR_RST);

    fb_state_e     state_q, state_d;
    logic [W-1:0]  foo_q, foo_d;
    logic [W-1:0]  bar_q, bar_d;
    logic          err_q, err_d;
    logic          pv_q, pv_d;
    logic          pop;
    logic          fifo_full, fifo_empty;
    logic [W-1:0]  head;

    fb_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_valid),
        .pop_i   (pop),
        .din_i   (wdata),
        .dout_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign wr_ready   = !fifo_full;
    assign pair_ok    = &(foo_q[CHECK_BITS-1:0] & bar_q[CHECK_BITS-1:0]);
    assign pair_valid = pv_q;
    assign foo        = foo_q;
    assign bar        = bar_q;
    assign err_seen   = err_q;

    always_comb begin
        state_d = state_q;
        foo_d   = foo_q;
        bar_d   = bar_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            LOAD_FOO: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    foo_d   = head;
                    state_d = LOAD_BAR;
                end
            end
            LOAD_BAR: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    bar_d   = head;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (rd) begin
                    state_d = LOAD_FOO;
                    if (!pair_ok) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = LOAD_FOO;
        endcase
        // pair_valid is kept as its own flop so it is not a decode of the state bits.
        pv_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_FOO;
            foo_q   <= FOO_INIT;
            bar_q   <= BAR_INIT;
            err_q   <= 1'b0;
            pv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            foo_q   <= foo_d;
            bar_q   <= bar_d;
            err_q   <= err_d;
            pv_q    <= pv_d;
        end
    end

endmodule
